// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: a CPU (port 0) and an I/O device (port 1) share one
// single-port RAM. Ties are broken round-robin against the last owner, each
// access holds the RAM for WAIT_CYCLES cycles, completion is a one-cycle ack,
// and a mandatory IDLE cycle separates consecutive grants (bus turnaround).
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata,
  output logic       busy
);

  // Counter holds WAIT_CYCLES-1 down to 0; WAIT_CYCLES is at most 8.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  // With a single access cycle the write strobe must rise on the grant edge.
  localparam logic WE_AT_GRANT = (WAIT_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner;       // 0 = CPU, 1 = I/O for the current transaction
  logic             last_owner;  // round-robin pointer: owner of the last completed access
  logic             lat_we;      // write/read flag captured at grant

  logic             any_req;
  logic             pick1;
  logic             win_we;
  logic [7:0]       win_addr;
  logic [7:0]       win_wdata;

  // Arbitration: on a tie the requester that did not own the RAM last time wins.
  always_comb begin
    any_req   = req0 | req1;
    pick1     = req1 & (~req0 | ~last_owner);
    win_we    = pick1 ? we1    : we0;
    win_addr  = pick1 ? addr1  : addr0;
    win_wdata = pick1 ? wdata1 : wdata0;
  end

  // Arbiter FSM; every output is a register so the RAM sees glitch-free controls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_we     <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            owner     <= pick1;
            gnt0      <= ~pick1;
            gnt1      <= pick1;
            lat_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_we    <= win_we & WE_AT_GRANT;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
          end
        end

        ACCESS: begin
          if (cnt != '0) begin
            // Strobe the write only in the final access cycle.
            cnt    <= cnt - 1'b1;
            mem_we <= lat_we & (cnt == CNT_W'(1));
          end else begin
            state     <= DONE;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!lat_we) begin
              rdata <= mem_rdata;
            end
            ack0 <= ~owner;
            ack1 <= owner;
          end
        end

        DONE: begin
          // Returning to IDLE costs one cycle: that is the bus turnaround.
          state      <= IDLE;
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          gnt0       <= 1'b0;
          gnt1       <= 1'b0;
          busy       <= 1'b0;
          last_owner <= owner;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with WAIT_CYCLES=1 (suffix _a)
// and one with WAIT_CYCLES=3 (suffix _b) share the requester inputs, each
// backed by its own behavioural RAM.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       ram_load;

  logic       gnt0_a, gnt1_a, ack0_a, ack1_a, mem_we_a, busy_a;
  logic [7:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic       gnt0_b, gnt1_b, ack0_b, ack1_b, mem_we_b, busy_b;
  logic [7:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];

  int checks;
  int errors;
  logic pa0_a, pa1_a, pa0_b, pa1_b;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .ack0(ack0_a), .ack1(ack1_a),
    .rdata(rdata_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_we(mem_we_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .ack0(ack0_b), .ack1(ack1_b),
    .rdata(rdata_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_we(mem_we_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
  );

  assign mem_rdata_a = ram_a[mem_addr_a];
  assign mem_rdata_b = ram_b[mem_addr_b];

  // RAM models: preload RAM[i] = i ^ 0xB5, then accept strobed writes.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) begin
        ram_a[i] <= 8'(i) ^ 8'hB5;
        ram_b[i] <= 8'(i) ^ 8'hB5;
      end
    end else begin
      if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
    end
  end

  task automatic chk1(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, got, want);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, got, want);
    end
  endtask

  // One clock: let the rising edge pass, sample on the falling edge, and
  // check the always-true properties (exclusive grants/acks, one-cycle acks).
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    chk1("gnt_excl_a", gnt0_a & gnt1_a, 1'b0);
    chk1("ack_excl_a", ack0_a & ack1_a, 1'b0);
    chk1("ack_width_a", (ack0_a & pa0_a) | (ack1_a & pa1_a), 1'b0);
    chk1("gnt_excl_b", gnt0_b & gnt1_b, 1'b0);
    chk1("ack_excl_b", ack0_b & ack1_b, 1'b0);
    chk1("ack_width_b", (ack0_b & pa0_b) | (ack1_b & pa1_b), 1'b0);
    pa0_a = ack0_a;
    pa1_a = ack1_a;
    pa0_b = ack0_b;
    pa1_b = ack1_b;
  endtask

  // Drop all requests and wait (bounded) for both arbiters to go idle.
  task automatic drain();
    req0 = 1'b0;
    req1 = 1'b0;
    we0  = 1'b0;
    we1  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!busy_a && !busy_b) break;
      tick();
    end
    chk1("drain_busy", busy_a | busy_b, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pa0_a = 1'b0; pa1_a = 1'b0; pa0_b = 1'b0; pa1_b = 1'b0;
    reset = 1'b0; ram_load = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;

    // Asynchronous reset, observed before any clock edge
    #2 reset = 1'b1;
    #1;
    chk1("rst_gnt0_a", gnt0_a, 1'b0);
    chk1("rst_gnt1_a", gnt1_a, 1'b0);
    chk1("rst_ack0_a", ack0_a, 1'b0);
    chk1("rst_ack1_a", ack1_a, 1'b0);
    chk1("rst_busy_a", busy_a, 1'b0);
    chk1("rst_mem_we_a", mem_we_a, 1'b0);
    chk8("rst_rdata_a", rdata_a, 8'h00);
    chk8("rst_mem_addr_a", mem_addr_a, 8'h00);
    chk8("rst_mem_wdata_a", mem_wdata_a, 8'h00);
    chk1("rst_gnt0_b", gnt0_b, 1'b0);
    chk1("rst_busy_b", busy_b, 1'b0);
    chk8("rst_mem_addr_b", mem_addr_b, 8'h00);
    tick();
    reset = 1'b0;
    ram_load = 1'b0;

    // CPU read of 0x10 (RAM = 0xA5); owner inputs change after grant
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    tick();
    chk1("rd_gnt0_a", gnt0_a, 1'b1);
    chk1("rd_gnt1_a", gnt1_a, 1'b0);
    chk1("rd_busy_a", busy_a, 1'b1);
    chk8("rd_mem_addr_a", mem_addr_a, 8'h10);
    chk1("rd_mem_we_a", mem_we_a, 1'b0);
    chk1("rd_ack0_early_a", ack0_a, 1'b0);
    chk1("rd_gnt0_b", gnt0_b, 1'b1);
    chk8("rd_mem_addr_b", mem_addr_b, 8'h10);
    we0 = 1'b1; addr0 = 8'h55; wdata0 = 8'hEE;
    tick();
    chk1("rd_ack0_a", ack0_a, 1'b1);
    chk1("rd_gnt0_done_a", gnt0_a, 1'b1);
    chk8("rd_rdata_a", rdata_a, 8'hA5);
    chk1("rd_ack0_early_b", ack0_b, 1'b0);
    chk8("rd_addr_hold_b", mem_addr_b, 8'h10);
    req0 = 1'b0;
    tick();
    chk1("rd_gnt0_off_a", gnt0_a, 1'b0);
    chk1("rd_ack0_off_a", ack0_a, 1'b0);
    chk1("rd_busy_off_a", busy_a, 1'b0);
    chk8("rd_idle_addr_a", mem_addr_a, 8'h00);
    chk1("rd_gnt0_held_b", gnt0_b, 1'b1);
    chk1("rd_no_we_b", mem_we_b, 1'b0);
    chk8("rd_addr_latched_b", mem_addr_b, 8'h10);
    tick();
    chk1("rd_ack0_b", ack0_b, 1'b1);
    chk8("rd_rdata_b", rdata_b, 8'hA5);
    chk1("rd_no_gnt1_b", gnt1_b, 1'b0);
    chk1("rd_idle_a", busy_a, 1'b0);
    tick();
    chk1("rd_gnt0_off_b", gnt0_b, 1'b0);
    chk1("rd_busy_off_b", busy_b, 1'b0);
    chk1("rd_ack0_off_b", ack0_b, 1'b0);

    // I/O write of 0x3C to 0x20
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h20; wdata1 = 8'h3C;
    tick();
    chk1("wr_gnt1_a", gnt1_a, 1'b1);
    chk1("wr_mem_we_a", mem_we_a, 1'b1);
    chk8("wr_mem_addr_a", mem_addr_a, 8'h20);
    chk8("wr_mem_wdata_a", mem_wdata_a, 8'h3C);
    chk1("wr_gnt1_b", gnt1_b, 1'b1);
    chk1("wr_we_c1_b", mem_we_b, 1'b0);
    chk8("wr_mem_addr_b", mem_addr_b, 8'h20);
    chk8("wr_mem_wdata_b", mem_wdata_b, 8'h3C);
    tick();
    chk1("wr_ack1_a", ack1_a, 1'b1);
    chk1("wr_we_off_a", mem_we_a, 1'b0);
    chk8("wr_rdata_keep_a", rdata_a, 8'hA5);
    chk1("wr_we_c2_b", mem_we_b, 1'b0);
    chk1("wr_ack1_early_b", ack1_b, 1'b0);
    tick();
    chk1("wr_we_c3_b", mem_we_b, 1'b1);
    chk8("wr_we_addr_b", mem_addr_b, 8'h20);
    chk8("wr_we_data_b", mem_wdata_b, 8'h3C);
    chk1("wr_gnt1_off_a", gnt1_a, 1'b0);
    tick();
    chk1("wr_we_done_b", mem_we_b, 1'b0);
    chk1("wr_ack1_b", ack1_b, 1'b1);
    chk1("wr_gnt1_done_b", gnt1_b, 1'b1);
    chk8("wr_rdata_keep_b", rdata_b, 8'hA5);
    drain();

    // Read back 0x20 through both arbiters
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    tick();
    chk1("rb_gnt1_a", gnt1_a, 1'b1);
    chk1("rb_gnt1_b", gnt1_b, 1'b1);
    tick();
    chk1("rb_ack1_a", ack1_a, 1'b1);
    chk8("rb_rdata_a", rdata_a, 8'h3C);
    tick();
    tick();
    chk1("rb_ack1_b", ack1_b, 1'b1);
    chk8("rb_rdata_b", rdata_b, 8'h3C);
    drain();

    // Tie after reset: CPU, then I/O after the turnaround, then CPU again
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    tick();
    chk1("tie1_gnt0_a", gnt0_a, 1'b1);
    chk1("tie1_gnt1_a", gnt1_a, 1'b0);
    chk8("tie1_addr_a", mem_addr_a, 8'h10);
    chk1("tie1_gnt0_b", gnt0_b, 1'b1);
    chk1("tie1_gnt1_b", gnt1_b, 1'b0);
    tick();
    chk1("tie1_ack0_a", ack0_a, 1'b1);
    chk8("tie1_rdata_a", rdata_a, 8'hA5);
    chk1("tie1_ack1_a", ack1_a, 1'b0);
    req0 = 1'b0;
    tick();
    chk1("tie_turn_gnt0_a", gnt0_a, 1'b0);
    chk1("tie_turn_gnt1_a", gnt1_a, 1'b0);
    chk1("tie_turn_busy_a", busy_a, 1'b0);
    tick();
    chk1("tie2_gnt1_a", gnt1_a, 1'b1);
    chk8("tie2_addr_a", mem_addr_a, 8'h20);
    chk1("tie1_ack0_b", ack0_b, 1'b1);
    tick();
    chk1("tie2_ack1_a", ack1_a, 1'b1);
    chk8("tie2_rdata_a", rdata_a, 8'h3C);
    req0 = 1'b1;
    tick();
    chk1("tie3_idle_a", busy_a, 1'b0);
    chk1("tie2_gnt1_b", gnt1_b, 1'b1);
    chk1("tie2_gnt0_b", gnt0_b, 1'b0);
    tick();
    chk1("tie3_gnt0_a", gnt0_a, 1'b1);
    chk1("tie3_gnt1_a", gnt1_a, 1'b0);
    tick();
    chk1("tie3_ack0_a", ack0_a, 1'b1);
    chk8("tie3_rdata_a", rdata_a, 8'hA5);
    drain();

    // Reset in the 2nd access cycle of a write on the 3-cycle arbiter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h30; wdata1 = 8'h77;
    tick();
    chk1("rw_gnt1_b", gnt1_b, 1'b1);
    chk1("rw_we_c1_b", mem_we_b, 1'b0);
    tick();
    chk1("rw_we_c2_b", mem_we_b, 1'b0);
    chk1("rw_gnt1_c2_b", gnt1_b, 1'b1);
    reset = 1'b1; req1 = 1'b0; we1 = 1'b0;
    #1;
    chk1("rw_rst_gnt1_b", gnt1_b, 1'b0);
    chk1("rw_rst_busy_b", busy_b, 1'b0);
    chk1("rw_rst_we_b", mem_we_b, 1'b0);
    chk1("rw_rst_ack1_b", ack1_b, 1'b0);
    chk8("rw_rst_addr_b", mem_addr_b, 8'h00);
    chk8("rw_rst_wdata_b", mem_wdata_b, 8'h00);
    chk8("rw_rst_rdata_b", rdata_b, 8'h00);
    chk1("rw_rst_gnt1_a", gnt1_a, 1'b0);
    chk1("rw_rst_ack1_a", ack1_a, 1'b0);
    tick();
    chk1("rw_hold_we_b", mem_we_b, 1'b0);
    chk1("rw_hold_ack1_b", ack1_b, 1'b0);
    chk1("rw_hold_busy_b", busy_b, 1'b0);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h30;
    tick();
    chk1("rw_next_gnt0_b", gnt0_b, 1'b1);
    chk8("rw_next_addr_b", mem_addr_b, 8'h30);
    tick();
    tick();
    chk1("rw_next_ack_early_b", ack0_b, 1'b0);
    tick();
    chk1("rw_next_ack0_b", ack0_b, 1'b1);
    chk8("rw_next_rdata_b", rdata_b, 8'h85);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
